spi_master_ctrl: RTL and testbench

- System-clock SPI master (mode 0: CPOL=0, CPHA=0) that generates sck/cs for the 16-bit SPI device-side shift port and serialises words into it.
- Sits directly upstream of that port: drives its sck, sdi and cs; samples its sdo.
- Exposes valid/ready word interfaces toward core logic (Sobel/GCD data movers). Supports single-word frames and multi-word bursts under one cs assertion.

---
 rtl/spi_master_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master: drives sck/cs/sdo into a 16-bit device shift port, samples sdi.
// Valid/ready word interfaces with single-word frames and multi-word bursts under one cs.
module spi_master_ctrl #(
  parameter int unsigned WORD_SIZE = 16,
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned CS_GAP    = 2
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic [WORD_SIZE-1:0] tx_data_i,
  input  logic                 tx_last_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  input  logic                 abort_i,
  output logic [WORD_SIZE-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 busy_o,
  output logic                 sck_o,
  output logic                 cs_o,
  output logic                 sdo_o,
  input  logic                 sdi_i
);

  localparam int unsigned BIT_W = $clog2(WORD_SIZE + 1);
  localparam int unsigned GAP_W = $clog2(CS_GAP + 1);
  localparam logic [7:0]       DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_XFER,
    S_WAIT,
    S_GAP
  } state_t;

  state_t               r_state,    w_state_n;
  logic [7:0]           r_div_cnt,  w_div_cnt_n;
  logic [BIT_W-1:0]     r_bit_cnt,  w_bit_cnt_n;
  logic [GAP_W-1:0]     r_gap_cnt,  w_gap_cnt_n;
  logic [WORD_SIZE-1:0] r_tx_shift, w_tx_shift_n;
  logic [WORD_SIZE-1:0] r_rx_shift, w_rx_shift_n;
  logic [WORD_SIZE-1:0] r_rx_data,  w_rx_data_n;
  logic                 r_last,     w_last_n;
  logic                 r_sck,      w_sck_n;
  logic                 r_cs,       w_cs_n;
  logic                 r_sdo,      w_sdo_n;
  logic                 r_rx_valid, w_rx_valid_n;

  logic                 w_accept;
  logic                 w_abort;
  logic [WORD_SIZE-1:0] w_tx_shifted;

  assign tx_ready_o   = (r_state == S_IDLE) | (r_state == S_WAIT);
  assign busy_o       = (r_state != S_IDLE);
  assign w_accept     = tx_valid_i & tx_ready_o;
  assign w_abort      = abort_i & ((r_state == S_SETUP) | (r_state == S_XFER) | (r_state == S_WAIT));
  assign w_tx_shifted = r_tx_shift << 1;

  assign sck_o      = r_sck;
  assign cs_o       = r_cs;
  assign sdo_o      = r_sdo;
  assign rx_data_o  = r_rx_data;
  assign rx_valid_o = r_rx_valid;

  always_comb begin
    w_state_n    = r_state;
    w_div_cnt_n  = r_div_cnt;
    w_bit_cnt_n  = r_bit_cnt;
    w_gap_cnt_n  = r_gap_cnt;
    w_tx_shift_n = r_tx_shift;
    w_rx_shift_n = r_rx_shift;
    w_rx_data_n  = r_rx_data;
    w_last_n     = r_last;
    w_sck_n      = r_sck;
    w_cs_n       = r_cs;
    w_sdo_n      = r_sdo;
    w_rx_valid_n = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_tx_shift_n = tx_data_i;
          w_last_n     = tx_last_i;
          w_sdo_n      = tx_data_i[WORD_SIZE-1];
          w_cs_n       = 1'b0;
          w_div_cnt_n  = '0;
          w_bit_cnt_n  = '0;
          w_state_n    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_cnt_n = '0;
          w_state_n   = S_XFER;
        end else begin
          w_div_cnt_n = r_div_cnt + 8'd1;
        end
      end
      S_XFER: begin
        if (r_div_cnt == DIV_LAST) begin
          w_div_cnt_n = '0;
          w_sck_n     = ~r_sck;
          if (!r_sck) begin
            w_rx_shift_n = {r_rx_shift[WORD_SIZE-2:0], sdi_i};
          end else if (r_bit_cnt == BIT_LAST) begin
            // Final falling edge: word complete, rx shift already holds all bits.
            w_bit_cnt_n  = '0;
            w_rx_data_n  = r_rx_shift;
            w_rx_valid_n = 1'b1;
            if (r_last) begin
              w_cs_n      = 1'b1;
              w_sdo_n     = 1'b0;
              w_gap_cnt_n = '0;
              w_state_n   = S_GAP;
            end else begin
              w_state_n   = S_WAIT;
            end
          end else begin
            w_bit_cnt_n  = r_bit_cnt + 1'b1;
            w_tx_shift_n = w_tx_shifted;
            w_sdo_n      = w_tx_shifted[WORD_SIZE-1];
          end
        end else begin
          w_div_cnt_n = r_div_cnt + 8'd1;
        end
      end
      S_WAIT: begin
        if (w_accept) begin
          w_tx_shift_n = tx_data_i;
          w_last_n     = tx_last_i;
          w_sdo_n      = tx_data_i[WORD_SIZE-1];
          w_div_cnt_n  = '0;
          w_bit_cnt_n  = '0;
          w_state_n    = S_XFER;
        end
      end
      S_GAP: begin
        if (w_gap_cnt_n == GAP_LAST && r_gap_cnt == GAP_LAST) begin
          w_gap_cnt_n = '0;
          w_state_n   = S_IDLE;
        end else begin
          w_gap_cnt_n = r_gap_cnt + 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase

    // Abort overrides everything, including a coincident final edge or accept.
    if (w_abort) begin
      w_state_n    = S_GAP;
      w_cs_n       = 1'b1;
      w_sck_n      = 1'b0;
      w_sdo_n      = 1'b0;
      w_div_cnt_n  = '0;
      w_bit_cnt_n  = '0;
      w_gap_cnt_n  = '0;
      w_tx_shift_n = r_tx_shift;
      w_last_n     = r_last;
      w_rx_data_n  = r_rx_data;
      w_rx_valid_n = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      r_state    <= S_IDLE;
      r_div_cnt  <= '0;
      r_bit_cnt  <= '0;
      r_gap_cnt  <= '0;
      r_tx_shift <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_last     <= 1'b0;
      r_sck      <= 1'b0;
      r_cs       <= 1'b1;
      r_sdo      <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_div_cnt  <= w_div_cnt_n;
      r_bit_cnt  <= w_bit_cnt_n;
      r_gap_cnt  <= w_gap_cnt_n;
      r_tx_shift <= w_tx_shift_n;
      r_rx_shift <= w_rx_shift_n;
      r_rx_data  <= w_rx_data_n;
      r_last     <= w_last_n;
      r_sck      <= w_sck_n;
      r_cs       <= w_cs_n;
      r_sdo      <= w_sdo_n;
      r_rx_valid <= w_rx_valid_n;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: mode-0 slave model plus scoreboard on rx words and slave captures.
// A second instance with CLK_DIV=1 runs in sdo->sdi loopback.
`timescale 1ns/1ps
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic nreset;

  logic [15:0] tx_data1, rx_data1;
  logic tx_last1, tx_valid1, tx_ready1, abort1, rx_valid1, busy1, sck1, cs1, sdo1, sdi1;
  logic [15:0] tx_data2, rx_data2;
  logic tx_last2, tx_valid2, tx_ready2, abort2, rx_valid2, busy2, sck2, cs2, sdo2;

  spi_master_ctrl #(.WORD_SIZE(16), .CLK_DIV(4), .CS_GAP(2)) u_dut (
    .clk_i(clk), .nreset_i(nreset), .tx_data_i(tx_data1), .tx_last_i(tx_last1),
    .tx_valid_i(tx_valid1), .tx_ready_o(tx_ready1), .abort_i(abort1),
    .rx_data_o(rx_data1), .rx_valid_o(rx_valid1), .busy_o(busy1),
    .sck_o(sck1), .cs_o(cs1), .sdo_o(sdo1), .sdi_i(sdi1));

  spi_master_ctrl #(.WORD_SIZE(16), .CLK_DIV(1), .CS_GAP(1)) u_loop (
    .clk_i(clk), .nreset_i(nreset), .tx_data_i(tx_data2), .tx_last_i(tx_last2),
    .tx_valid_i(tx_valid2), .tx_ready_o(tx_ready2), .abort_i(abort2),
    .rx_data_o(rx_data2), .rx_valid_o(rx_valid2), .busy_o(busy2),
    .sck_o(sck2), .cs_o(cs2), .sdo_o(sdo2), .sdi_i(sdo2));

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  function automatic void timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endfunction

  // Reference model: slave response words, model word index, scoreboards
  logic [15:0] resp_mem [0:63];
  int unsigned m_w = 0;
  logic [15:0] exp_rx1[$], exp_tx1[$], exp_rx2[$];

  // Observation counters
  int cyc = 0, cs1_low = 0, gap1 = 0, cs2_low = 0;
  int sck1_cnt = 0, cs1_rise = 0, rxv1_cnt = 0, rxv2_cnt = 0;
  int sck2_t[$];

  initial forever begin
    @(negedge clk);
    cyc++;
    if (cs1 === 1'b0) cs1_low++;
    if (cs2 === 1'b0) cs2_low++;
    if (busy1 === 1'b1 && cs1 === 1'b1) gap1++;
    if (rx_valid1 === 1'b1) begin
      rxv1_cnt++;
      if (exp_rx1.size() == 0) timeout("rx1_unexpected");
      else check("rx1_data", {16'h0, rx_data1}, {16'h0, exp_rx1.pop_front()});
    end
    if (rx_valid2 === 1'b1) begin
      rxv2_cnt++;
      if (exp_rx2.size() == 0) timeout("rx2_unexpected");
      else check("rx2_data", {16'h0, rx_data2}, {16'h0, exp_rx2.pop_front()});
    end
  end

  initial forever begin @(posedge cs1); cs1_rise++; end
  initial forever begin @(posedge sck2); sck2_t.push_back(cyc); end

  // Mode-0 slave on DUT1: captures on rising sck, presents next bit after falling sck
  logic [5:0]  s_w = '0;
  logic [3:0]  s_idx = '0;
  logic [4:0]  s_bits = '0;
  logic [15:0] s_cap = '0;
  assign sdi1 = (cs1 !== 1'b0) ? 1'b0 : resp_mem[s_w][4'd15 - s_idx];

  initial forever begin @(negedge cs1); s_idx = '0; s_bits = '0; end
  initial forever begin @(posedge cs1); s_idx = '0; s_bits = '0; end
  initial forever begin @(negedge sck1); if (cs1 === 1'b0) s_idx = s_idx + 4'd1; end
  initial forever begin
    @(posedge sck1);
    sck1_cnt++;
    if (cs1 === 1'b0) begin
      s_cap = {s_cap[14:0], sdo1};
      if (s_bits == 5'd15) begin
        s_bits = '0;
        s_w = s_w + 6'd1;
        if (exp_tx1.size() == 0) timeout("slave_unexpected");
        else check("slave_capture", {16'h0, s_cap}, {16'h0, exp_tx1.pop_front()});
      end else begin
        s_bits = s_bits + 5'd1;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int sel, input logic [15:0] d, input logic last, input bit hold, input bit expect_ok);
    int n = 0;
    if (sel == 0) begin tx_data1 = d; tx_last1 = last; tx_valid1 = 1'b1; end
    else begin tx_data2 = d; tx_last2 = last; tx_valid2 = 1'b1; end
    while (!(sel == 0 ? tx_ready1 : tx_ready2) && n < 3000) begin tick(); n++; end
    if (n >= 3000) timeout("accept");
    if (expect_ok) begin
      if (sel == 0) begin exp_tx1.push_back(d); exp_rx1.push_back(resp_mem[m_w]); m_w++; end
      else exp_rx2.push_back(d);
    end
    tick();
    if (!hold) begin
      if (sel == 0) tx_valid1 = 1'b0; else tx_valid2 = 1'b0;
    end
  endtask

  task automatic wait_idle(input int sel);
    int n = 0;
    while ((sel == 0 ? busy1 : busy2) && n < 5000) begin tick(); n++; end
    if (n >= 5000) timeout("idle");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int c0, s0, r0, g0, e0, n, viol;
    logic [15:0] d;
    nreset = 1'b0;
    tx_data1 = '0; tx_last1 = 1'b0; tx_valid1 = 1'b0; abort1 = 1'b0;
    tx_data2 = '0; tx_last2 = 1'b0; tx_valid2 = 1'b0; abort2 = 1'b0;
    for (int i = 0; i < 64; i++) resp_mem[i] = 16'($urandom) | 16'h0001;
    resp_mem[0] = 16'h1234;
    repeat (3) tick();

    check("rst_cs", {31'h0, cs1}, 1);
    check("rst_sck", {31'h0, sck1}, 0);
    check("rst_sdo", {31'h0, sdo1}, 0);
    check("rst_rx_data", {16'h0, rx_data1}, 0);
    check("rst_rx_valid", {31'h0, rx_valid1}, 0);
    check("rst_busy", {31'h0, busy1}, 0);
    check("rst_ready", {31'h0, tx_ready1}, 1);
    nreset = 1'b1;
    repeat (2) tick();

    // Single frame
    c0 = cs1_low; s0 = sck1_cnt; r0 = rxv1_cnt; g0 = gap1;
    send(0, 16'hA5C3, 1'b1, 1'b0, 1'b1);
    wait_idle(0);
    check("t1_cs_low_cycles", cs1_low - c0, 132);
    check("t1_sck_pulses", sck1_cnt - s0, 16);
    check("t1_rx_pulses", rxv1_cnt - r0, 1);
    check("t1_gap_cycles", gap1 - g0, 2);
    check("t1_ready", {31'h0, tx_ready1}, 1);

    // Burst of three, valid held
    c0 = cs1_low; s0 = sck1_cnt; r0 = rxv1_cnt; e0 = cs1_rise;
    send(0, 16'h0001, 1'b0, 1'b1, 1'b1);
    send(0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(0, 16'hFFFF, 1'b1, 1'b0, 1'b1);
    wait_idle(0);
    check("t2_sck_pulses", sck1_cnt - s0, 48);
    check("t2_rx_pulses", rxv1_cnt - r0, 3);
    check("t2_cs_rises", cs1_rise - e0, 1);
    check("t2_cs_low_cycles", cs1_low - c0, 390);

    // Burst with 50-cycle stall after word 1
    send(0, 16'($urandom), 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!(busy1 && tx_ready1) && n < 3000) begin tick(); n++; end
    if (n >= 3000) timeout("t3_reach_wait");
    s0 = sck1_cnt; viol = 0;
    for (int i = 0; i < 50; i++) begin
      if (sck1 !== 1'b0 || cs1 !== 1'b0 || busy1 !== 1'b1 || tx_ready1 !== 1'b1) viol++;
      tick();
    end
    check("t3_stall_violations", viol, 0);
    check("t3_stall_sck_pulses", sck1_cnt - s0, 0);
    send(0, 16'($urandom), 1'b1, 1'b0, 1'b1);
    wait_idle(0);

    // Abort after 7 rising edges
    s0 = sck1_cnt; r0 = rxv1_cnt;
    send(0, 16'($urandom), 1'b1, 1'b0, 1'b0);
    n = 0;
    while (sck1_cnt - s0 < 7 && n < 3000) begin tick(); n++; end
    if (n >= 3000) timeout("t4_seven_edges");
    abort1 = 1'b1;
    tick();
    abort1 = 1'b0;
    check("t4_cs_after_abort", {31'h0, cs1}, 1);
    check("t4_sck_after_abort", {31'h0, sck1}, 0);
    n = 0;
    while (busy1 && n < 100) begin tick(); n++; end
    check("t4_busy_gap_cycles", n, 2);
    check("t4_sck_pulses", sck1_cnt - s0, 7);
    check("t4_no_rx_valid", rxv1_cnt - r0, 0);
    send(0, 16'h5A5A, 1'b1, 1'b0, 1'b1);
    wait_idle(0);

    // Asynchronous reset mid-transfer
    send(0, 16'($urandom), 1'b1, 1'b0, 1'b0);
    repeat (40) tick();
    check("t5_pre_cs_low", {31'h0, cs1}, 0);
    check("t5_pre_rx_nonzero", {31'h0, (rx_data1 != 16'h0)}, 1);
    #2;
    nreset = 1'b0;
    #1;
    check("t5_rst_cs", {31'h0, cs1}, 1);
    check("t5_rst_sck", {31'h0, sck1}, 0);
    check("t5_rst_rx_data", {16'h0, rx_data1}, 0);
    check("t5_rst_busy", {31'h0, busy1}, 0);
    tick();
    nreset = 1'b1;
    tick();
    d = 16'($urandom);
    send(0, d, 1'b1, 1'b0, 1'b1);
    wait_idle(0);

    // CLK_DIV=1 loopback
    c0 = cs2_low; r0 = rxv2_cnt;
    sck2_t.delete();
    send(1, 16'h3C3C, 1'b1, 1'b0, 1'b1);
    wait_idle(1);
    check("t6_sck_pulses", sck2_t.size(), 16);
    viol = 0;
    for (int i = 1; i < sck2_t.size(); i++) if (sck2_t[i] - sck2_t[i-1] != 2) viol++;
    check("t6_sck_period_violations", viol, 0);
    check("t6_cs_low_cycles", cs2_low - c0, 33);
    send(1, 16'($urandom), 1'b0, 1'b1, 1'b1);
    send(1, 16'($urandom), 1'b1, 1'b0, 1'b1);
    wait_idle(1);
    check("t6_rx_pulses", rxv2_cnt - r0, 3);

    repeat (4) tick();
    check("end_exp_rx1_empty", exp_rx1.size(), 0);
    check("end_exp_tx1_empty", exp_tx1.size(), 0);
    check("end_exp_rx2_empty", exp_rx2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
